// File: rtl/audioport_pkg.sv
// Shared types and default parameters for the audio port control path.
package audioport_pkg;

    localparam int AUDIO_W_DEF       = 24;
    localparam int FIFO_DEPTH_DEF    = 8;
    localparam int IRQ_THRESHOLD_DEF = 4;
    localparam int CFG_WAIT_DEF      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        PLAY   = 2'd2
    } seq_state_t;

    typedef logic [1:0][AUDIO_W_DEF-1:0] stereo_t;

endpackage

// File: rtl/stereo_fifo.sv
// Stereo-pair FIFO: pointer and occupancy logic with a synchronous flush.
module stereo_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [1:0][W-1:0]            wdata,
    output logic [1:0][W-1:0]            rdata,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [1:0][W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; clear flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            level  <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Sample storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/audio_sequencer.sv
// Audio port sequencer: command FSM, sample request service and buffer-low interrupt.
module audio_sequencer
    import audioport_pkg::*;
#(
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int AUDIO_W       = AUDIO_W_DEF,
    parameter int IRQ_THRESHOLD = IRQ_THRESHOLD_DEF,
    parameter int CFG_WAIT      = CFG_WAIT_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_in,
    input  logic                              stop_in,
    input  logic                              clr_in,
    input  logic                              cfg_in,
    input  logic                              wr_in,
    input  logic [1:0][AUDIO_W-1:0]           wdata_in,
    input  logic                              req_in,
    input  logic                              irq_ack_in,
    output logic [1:0][AUDIO_W-1:0]           abuf_out,
    output logic                              tick_out,
    output logic                              play_out,
    output logic                              cfg_out,
    output logic                              clr_out,
    output logic                              irq_out,
    output logic                              underrun_out,
    output logic                              full_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_out
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(CFG_WAIT + 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_CONFIG = CONFIG;
    localparam logic [1:0] S_PLAY   = PLAY;

    logic [1:0]               state;
    logic [CW-1:0]            cfg_cnt;
    logic                     arm;
    logic                     serve;
    logic                     push_ok;
    logic                     pop_ok;
    logic                     fifo_empty;
    logic [1:0][AUDIO_W-1:0]  head;
    logic [LW-1:0]            level_next;

    assign play_out = (state == S_PLAY);
    assign serve    = req_in && (state == S_PLAY) && !clr_in;
    assign push_ok  = wr_in && !clr_in && !full_out;
    assign pop_ok   = serve && !fifo_empty;

    // Occupancy the FIFO will hold after this cycle, used for the interrupt decision.
    always_comb begin
        level_next = level_out + LW'(push_ok) - LW'(pop_ok);
    end

    stereo_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (AUDIO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop_ok),
        .clear (clr_in),
        .wdata (wdata_in),
        .rdata (head),
        .level (level_out),
        .full  (full_out),
        .empty (fifo_empty)
    );

    // Command FSM: configure wins over start in IDLE, stop wins in PLAY, CONFIG ignores commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cfg_cnt <= '0;
            cfg_out <= 1'b0;
        end else begin
            cfg_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_in) begin
                        state   <= S_CONFIG;
                        cfg_cnt <= CW'(CFG_WAIT);
                        cfg_out <= 1'b1;
                    end else if (start_in) begin
                        state <= S_PLAY;
                    end
                end
                S_CONFIG: begin
                    cfg_cnt <= cfg_cnt - CW'(1);
                    if (cfg_cnt == CW'(1)) begin
                        state <= S_IDLE;
                    end
                end
                S_PLAY: begin
                    if (stop_in) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request service: present the FIFO head (or silence on underrun) with a one-cycle tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abuf_out     <= '0;
            tick_out     <= 1'b0;
            underrun_out <= 1'b0;
            clr_out      <= 1'b0;
        end else begin
            tick_out <= 1'b0;
            clr_out  <= 1'b0;
            if (clr_in) begin
                abuf_out     <= '0;
                underrun_out <= 1'b0;
                clr_out      <= 1'b1;
            end else if (serve) begin
                tick_out <= 1'b1;
                if (fifo_empty) begin
                    abuf_out     <= '0;
                    underrun_out <= 1'b1;
                end else begin
                    abuf_out <= head;
                end
            end
        end
    end

    // Buffer-low interrupt fires once per arming; arming returns when the level rises above threshold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_out <= 1'b0;
            arm     <= 1'b1;
        end else if (clr_in) begin
            irq_out <= 1'b0;
            arm     <= 1'b1;
        end else if ((state == S_PLAY) && arm && (level_next <= LW'(IRQ_THRESHOLD))) begin
            irq_out <= 1'b1;
            arm     <= 1'b0;
        end else begin
            if (irq_ack_in) begin
                irq_out <= 1'b0;
            end
            if (level_out > LW'(IRQ_THRESHOLD)) begin
                arm <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_sequencer.sv
// Self-checking bench for audio_sequencer: vector table, directed corner cases, random vs model.
module tb_audio_sequencer;
    import audioport_pkg::*;

    localparam int DEPTH    = 8;
    localparam int TH       = 4;
    localparam int CFG_WAIT = 4;

    typedef struct {
        logic        start, stop, clr, cfg, wr, req, ack;
        logic [47:0] wdata;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        tick;
        logic [47:0] abuf;
        logic        play, irq, under;
        logic [3:0]  level;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_in, stop_in, clr_in, cfg_in, wr_in, req_in, irq_ack_in;
    stereo_t     wdata_in;
    stereo_t     abuf_out;
    logic        tick_out, play_out, cfg_out, clr_out, irq_out, underrun_out, full_out;
    logic [3:0]  level_out;

    int total = 0;
    int bad   = 0;

    // Behavioural model: state as a plain number, FIFO as a queue of pairs.
    int          m_state;
    int          m_cfg_left;
    logic [47:0] m_q[$];
    logic [47:0] m_abuf;
    bit          m_tick, m_cfgs, m_clrs, m_irq, m_under, m_arm;

    audio_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_in     (start_in),
        .stop_in      (stop_in),
        .clr_in       (clr_in),
        .cfg_in       (cfg_in),
        .wr_in        (wr_in),
        .wdata_in     (wdata_in),
        .req_in       (req_in),
        .irq_ack_in   (irq_ack_in),
        .abuf_out     (abuf_out),
        .tick_out     (tick_out),
        .play_out     (play_out),
        .cfg_out      (cfg_out),
        .clr_out      (clr_out),
        .irq_out      (irq_out),
        .underrun_out (underrun_out),
        .full_out     (full_out),
        .level_out    (level_out)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pair(input int l, input int r);
        return {r[23:0], l[23:0]};
    endfunction

    function automatic stim_t mk(input bit start, input bit stop, input bit clr, input bit cfg,
                                 input bit wr, input bit req, input bit ack, input logic [47:0] wd);
        stim_t s;
        s.start = start; s.stop = stop; s.clr = clr; s.cfg = cfg;
        s.wr = wr; s.req = req; s.ack = ack; s.wdata = wd;
        return s;
    endfunction

    task automatic cmp(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_state = 0; m_cfg_left = 0; m_q.delete(); m_abuf = '0;
        m_tick = 0; m_cfgs = 0; m_clrs = 0; m_irq = 0; m_under = 0; m_arm = 1;
    endtask

    task automatic modelStep(input stim_t s);
        int cur_state;
        int cur_level;
        cur_state = m_state;
        cur_level = m_q.size();
        m_tick = 0; m_cfgs = 0; m_clrs = 0;
        case (cur_state)
            0: if (s.cfg) begin m_state = 1; m_cfg_left = CFG_WAIT; m_cfgs = 1; end
               else if (s.start) m_state = 2;
            1: begin m_cfg_left--; if (m_cfg_left == 0) m_state = 0; end
            default: if (s.stop) m_state = 0;
        endcase
        if (s.clr) begin
            m_q.delete(); m_abuf = '0; m_under = 0; m_irq = 0; m_arm = 1; m_clrs = 1;
        end else begin
            if (cur_state == 2 && s.req) begin
                m_tick = 1;
                if (m_q.size() > 0) m_abuf = m_q.pop_front();
                else begin m_abuf = '0; m_under = 1; end
            end
            if (s.wr && cur_level < DEPTH) m_q.push_back(s.wdata);
            if (cur_state == 2 && m_arm && m_q.size() <= TH) begin
                m_irq = 1; m_arm = 0;
            end else begin
                if (s.ack) m_irq = 0;
                if (cur_level > TH) m_arm = 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".abuf"},  abuf_out,     m_abuf);
        cmp({tag, ".tick"},  tick_out,     m_tick);
        cmp({tag, ".play"},  play_out,     (m_state == 2));
        cmp({tag, ".cfg"},   cfg_out,      m_cfgs);
        cmp({tag, ".clr"},   clr_out,      m_clrs);
        cmp({tag, ".irq"},   irq_out,      m_irq);
        cmp({tag, ".under"}, underrun_out, m_under);
        cmp({tag, ".level"}, level_out,    48'(m_q.size()));
        cmp({tag, ".full"},  full_out,     (m_q.size() == DEPTH));
    endtask

    task automatic driveInputs(input stim_t s);
        start_in = s.start; stop_in = s.stop; clr_in = s.clr; cfg_in = s.cfg;
        wr_in = s.wr; req_in = s.req; irq_ack_in = s.ack; wdata_in = s.wdata;
    endtask

    task automatic applyStimulus(input stim_t s, input string tag);
        driveInputs(s);
        @(posedge clk);
        #1;
        modelStep(s);
        checkOutput(tag);
        driveInputs(mk(0, 0, 0, 0, 0, 0, 0, '0));
    endtask

    task automatic doReset(input string tag);
        driveInputs(mk(0, 0, 0, 0, 0, 0, 0, '0));
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t  tbl[13];
    stim_t idle;
    stim_t rs;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, '0);
        tbl[0]  = '{mk(0,0,0,0,1,0,0,pair(1,2)), 0, 48'h0,       0, 0, 0, 4'd1};
        tbl[1]  = '{mk(0,0,0,0,1,0,0,pair(3,4)), 0, 48'h0,       0, 0, 0, 4'd2};
        tbl[2]  = '{mk(0,0,0,0,1,0,0,pair(5,6)), 0, 48'h0,       0, 0, 0, 4'd3};
        tbl[3]  = '{mk(1,0,0,0,0,0,0,'0),        0, 48'h0,       1, 0, 0, 4'd3};
        tbl[4]  = '{mk(0,0,0,0,0,1,0,'0),        1, pair(1,2),   1, 1, 0, 4'd2};
        tbl[5]  = '{mk(0,0,0,0,0,0,0,'0),        0, pair(1,2),   1, 1, 0, 4'd2};
        tbl[6]  = '{mk(0,0,0,0,0,1,0,'0),        1, pair(3,4),   1, 1, 0, 4'd1};
        tbl[7]  = '{mk(0,0,0,0,0,1,0,'0),        1, pair(5,6),   1, 1, 0, 4'd0};
        tbl[8]  = '{mk(0,0,0,0,0,1,0,'0),        1, 48'h0,       1, 1, 1, 4'd0};
        tbl[9]  = '{mk(0,0,1,0,0,0,0,'0),        0, 48'h0,       1, 0, 0, 4'd0};
        tbl[10] = '{mk(0,1,0,0,0,0,0,'0),        0, 48'h0,       0, 1, 0, 4'd0};
        tbl[11] = '{mk(0,0,0,0,0,0,1,'0),        0, 48'h0,       0, 0, 0, 4'd0};
        tbl[12] = '{mk(0,0,0,0,0,1,0,'0),        0, 48'h0,       0, 0, 0, 4'd0};

        driveInputs(idle);
        #2;
        doReset("reset");
        applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, '0), "idle_req");
        cmp("idle_req.tick_const", tick_out, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].s, $sformatf("tbl%0d", i));
            cmp($sformatf("tbl%0d.tick_t", i),  tick_out,     tbl[i].tick);
            cmp($sformatf("tbl%0d.abuf_t", i),  abuf_out,     tbl[i].abuf);
            cmp($sformatf("tbl%0d.play_t", i),  play_out,     tbl[i].play);
            cmp($sformatf("tbl%0d.irq_t", i),   irq_out,      tbl[i].irq);
            cmp($sformatf("tbl%0d.under_t", i), underrun_out, tbl[i].under);
            cmp($sformatf("tbl%0d.level_t", i), level_out,    tbl[i].level);
        end

        // Three requests ten cycles apart
        doReset("gap_reset");
        for (int i = 0; i < 3; i++) applyStimulus(mk(0,0,0,0,1,0,0,pair(2*i+1, 2*i+2)), "gap_wr");
        applyStimulus(mk(1,0,0,0,0,0,0,'0), "gap_start");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mk(0,0,0,0,0,1,0,'0), "gap_req");
            cmp("gap.tick", tick_out, 1'b1);
            cmp("gap.abuf", abuf_out, pair(2*i+1, 2*i+2));
            for (int k = 0; k < 9; k++) applyStimulus(idle, "gap_idle");
        end
        cmp("gap.level0", level_out, 4'd0);

        // Fill to full and attempt one more write
        doReset("full_reset");
        for (int k = 1; k <= 9; k++) applyStimulus(mk(0,0,0,0,1,0,0,pair(k, 100+k)), "full_wr");
        cmp("full.flag", full_out, 1'b1);
        cmp("full.level", level_out, 4'd8);
        applyStimulus(mk(1,0,0,0,0,0,0,'0), "full_start");
        for (int k = 1; k <= 8; k++) applyStimulus(mk(0,0,0,0,0,1,0,'0), "full_pop");
        cmp("full.last", abuf_out, pair(8, 108));
        applyStimulus(mk(0,0,0,0,0,1,0,'0), "full_ninth");
        cmp("full.ninth_abuf", abuf_out, 48'h0);
        cmp("full.ninth_under", underrun_out, 1'b1);

        // Interrupt arming and re-fire
        doReset("irq_reset");
        for (int k = 0; k < 5; k++) applyStimulus(mk(0,0,0,0,1,0,0,pair(k, k)), "irq_wr");
        applyStimulus(mk(1,0,0,0,0,0,0,'0), "irq_start");
        cmp("irq.quiet_at5", irq_out, 1'b0);
        applyStimulus(mk(0,0,0,0,0,1,0,'0), "irq_pop1");
        cmp("irq.first_fire", irq_out, 1'b1);
        applyStimulus(mk(0,0,0,0,0,1,0,'0), "irq_pop2");
        applyStimulus(mk(0,0,0,0,0,0,1,'0), "irq_ack");
        cmp("irq.acked", irq_out, 1'b0);
        applyStimulus(mk(0,0,0,0,0,1,0,'0), "irq_pop3");
        cmp("irq.no_refire", irq_out, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(mk(0,0,0,0,1,0,0,pair(50+k, k)), "irq_refill");
        cmp("irq.level6", level_out, 4'd6);
        applyStimulus(mk(0,0,0,0,0,1,0,'0), "irq_pop4");
        cmp("irq.quiet_at5b", irq_out, 1'b0);
        applyStimulus(mk(0,0,0,0,0,1,0,'0), "irq_pop5");
        cmp("irq.refire", irq_out, 1'b1);

        // Underrun then clear while playing
        doReset("und_reset");
        applyStimulus(mk(1,0,0,0,0,0,0,'0), "und_start");
        applyStimulus(mk(0,0,0,0,0,1,0,'0), "und_req");
        cmp("und.tick", tick_out, 1'b1);
        cmp("und.flag", underrun_out, 1'b1);
        applyStimulus(mk(0,0,1,0,0,0,0,'0), "und_clr");
        cmp("und.clr_pulse", clr_out, 1'b1);
        cmp("und.cleared", underrun_out, 1'b0);
        cmp("und.play", play_out, 1'b1);

        // Configuration residency, start afterwards, cfg in PLAY, reset mid-play
        doReset("cfg_reset");
        applyStimulus(mk(0,0,0,1,0,0,0,'0), "cfg_cmd");
        cmp("cfg.pulse", cfg_out, 1'b1);
        for (int k = 0; k < CFG_WAIT; k++) begin
            applyStimulus(mk(1,0,0,0,0,0,0,'0), "cfg_hold");
            cmp("cfg.start_ignored", play_out, 1'b0);
        end
        applyStimulus(mk(1,0,0,0,0,0,0,'0), "cfg_start");
        cmp("cfg.start_taken", play_out, 1'b1);
        applyStimulus(mk(0,0,0,1,0,0,0,'0), "cfg_in_play");
        cmp("cfg.no_pulse_in_play", cfg_out, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus(mk(0,0,0,0,1,0,0,pair(k+9, k)), "mid_wr");
        applyStimulus(mk(0,0,0,0,0,1,0,'0), "mid_req");
        req_in = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("mid_rst");
        cmp("mid_rst.level", level_out, 4'd0);
        cmp("mid_rst.abuf", abuf_out, 48'h0);
        req_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(idle, "mid_after");
        cmp("mid_after.tick", tick_out, 1'b0);

        // Randomized traffic against the model
        doReset("rnd_reset");
        for (int n = 0; n < 1500; n++) begin
            rs.start = ($urandom_range(0, 15) == 0);
            rs.stop  = ($urandom_range(0, 31) == 0);
            rs.clr   = ($urandom_range(0, 63) == 0);
            rs.cfg   = ($urandom_range(0, 31) == 0);
            rs.wr    = ($urandom_range(0, 1) == 0);
            rs.req   = ($urandom_range(0, 2) == 0);
            rs.ack   = ($urandom_range(0, 7) == 0);
            rs.wdata = {24'($urandom()), 24'($urandom())};
            applyStimulus(rs, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_sequencer.md
Name: audio_sequencer

Overview:
- Control-domain sequencer between the APB register decode and the DSP/CDC datapath of the audio port.
- Buffers stereo samples written by software in a small FIFO.
- Sequences the configure/play/stop/clear operations.
- Answers each sample request from the CDC path by presenting the next stereo pair with a one-cycle tick.
- Raises a buffer-low interrupt so software can refill the FIFO.

Parameters:
- FIFO_DEPTH, 8, number of stereo pairs buffered; must be a power of two, minimum 2.
- AUDIO_W, 24, bits per channel sample.
- IRQ_THRESHOLD, 4, buffer-low level; must be less than FIFO_DEPTH.
- CFG_WAIT, 4, cycles the CONFIG state is held after cfg_out pulses; minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start_in  in  1  start-play command pulse
- stop_in  in  1  stop-play command pulse
- clr_in  in  1  clear command pulse
- cfg_in  in  1  apply-configuration command pulse
- wr_in  in  1  push one stereo pair
- wdata_in  in  [1:0][AUDIO_W-1:0]  stereo pair to push; index 0 = left
- req_in  in  1  sample request pulse from the CDC path
- irq_ack_in  in  1  interrupt acknowledge pulse
- abuf_out  out  [1:0][AUDIO_W-1:0]  current stereo pair to the DSP
- tick_out  out  1  abuf_out updated this cycle
- play_out  out  1  high while in PLAY
- cfg_out  out  1  one-cycle configuration strobe
- clr_out  out  1  one-cycle clear strobe
- irq_out  out  1  buffer-low interrupt, sticky
- underrun_out  out  1  sticky: a request was served while the FIFO was empty
- full_out  out  1  level_out == FIFO_DEPTH
- level_out  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Reset: state IDLE; FIFO empty; irq arm flag = 1. All outputs 0: abuf_out = 0, level_out = 0, full_out = 0.
- All outputs are registered.
- FSM states: IDLE, CONFIG, PLAY.
- IDLE transitions:
  - cfg_in -> CONFIG; cfg_out pulses in the next cycle; the wait counter loads CFG_WAIT.
  - start_in -> PLAY.
  - If cfg_in and start_in arrive together, cfg_in wins and start_in is dropped.
- CONFIG:
  - Counter decrements each cycle; at 0 -> IDLE.
  - start_in, stop_in and cfg_in are ignored.
  - Total CONFIG residency is CFG_WAIT cycles.
- PLAY:
  - play_out = 1.
  - stop_in -> IDLE; stop wins over any same-cycle command.
  - cfg_in and start_in are ignored.
- Serving a request (PLAY only):
  - req_in in cycle n: abuf_out and tick_out are updated in cycle n+1.
  - FIFO non-empty: pop the head into abuf_out.
  - FIFO empty: abuf_out <= 0, underrun_out <= 1, tick_out still pulses.
  - req_in outside PLAY is ignored; no tick_out.
- Write:
  - wr_in accepted only if level < FIFO_DEPTH at the start of the cycle; otherwise the write is silently dropped.
  - Same-cycle push and pop are both honoured; level is unchanged.
  - Push while empty plus a same-cycle request: underrun is served, then the pair is stored.
  - Pointers wrap modulo FIFO_DEPTH.
- Clear (clr_in), in any state:
  - Flush the FIFO; abuf_out <= 0; underrun_out <= 0; irq_out <= 0; arm <= 1.
  - clr_out pulses in the next cycle.
  - A same-cycle write or pop is discarded; no tick_out.
  - FSM state is unchanged.
- Interrupt:
  - Set in PLAY when arm = 1 and the next-cycle level <= IRQ_THRESHOLD; setting also clears arm.
  - irq_ack_in clears irq_out; set wins over a same-cycle ack.
  - arm re-sets whenever level > IRQ_THRESHOLD.
  - irq_out is not cleared by stop_in.
- Reset asserted mid-play: immediate return to reset values; no pending tick_out is emitted.

Decomposition:
- audioport_pkg additions:
  - seq_state_t enum {IDLE, CONFIG, PLAY}.
  - Defaults for AUDIO_W, FIFO_DEPTH, IRQ_THRESHOLD, CFG_WAIT.
  - stereo_t typedef, [1:0][AUDIO_W-1:0].
- Sub-module stereo_fifo:
  - Ports: push, pop, clear, data, level, full, empty.
  - Pointer and level logic only.
- FSM, request service and irq logic live in audio_sequencer.

Test Plan:
- Reset then idle: all outputs 0, level_out = 0; req_in pulses give no tick_out.
- Write 3 pairs ({1,2},{3,4},{5,6}), start_in, three req_in pulses 10 cycles apart -> three tick_out pulses, each one cycle after its req, with abuf_out {1,2},{3,4},{5,6}; then level_out = 0.
- Fill 8 pairs and attempt a 9th write -> full_out = 1, level_out stays 8, 9th pair never read.
- Play from level 5 with default IRQ_THRESHOLD = 4:
  - First pop -> irq_out = 1 one cycle after the pop.
  - Further pops -> no re-fire.
  - irq_ack_in -> irq_out = 0.
  - Refill to 6, then pop to 4 -> irq_out fires again.
- Play with an empty FIFO, req_in -> tick_out with abuf_out = 0 and underrun_out = 1; then clr_in -> clr_out pulse, underrun_out = 0, play_out stays 1.
- cfg_in in IDLE -> cfg_out pulse next cycle, FSM in CONFIG for 4 cycles ignoring start_in; then start_in accepted; cfg_in during PLAY gives no cfg_out; assert rst mid-play -> all outputs 0 immediately.
